// File: rtl/cla_sub_serial.sv
// Bit-serial subtractor: diff = a - b (mod 2^WIDTH), two bits per clock.
// Each RUN cycle one 2-bit carry-lookahead slice computes a + ~b + carry,
// with the carry registered between slices. Latency is WIDTH/2 cycles.
// Optional feature macro: SUB_OVF_EN adds the o_ovf signed-overflow output.
module cla_sub_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_clear,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_zero
`ifdef SUB_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH / 2 - 1);

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, w_a_nxt;
  logic [WIDTH-1:0]   r_nb, w_nb_nxt;
  logic [WIDTH-1:0]   r_diff, w_diff_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_carry, w_carry_nxt;
  logic               r_borrow, w_borrow_nxt;
  logic               r_zero, w_zero_nxt;
`ifdef SUB_OVF_EN
  logic               r_b_msb, w_b_msb_nxt;
  logic               r_ovf, w_ovf_nxt;
`endif

  // Slice datapath signals
  logic [CNT_W:0]     w_bit_idx;
  logic [1:0]         w_a_sl;
  logic [1:0]         w_nb_sl;
  logic [1:0]         w_g;
  logic [1:0]         w_p;
  logic               w_c1;
  logic               w_cout;
  logic [1:0]         w_s;
  logic [WIDTH-1:0]   w_slice_diff;
  logic               w_last;

  // Current 2-bit lookahead slice selected by the counter
  always_comb begin
    w_bit_idx    = {r_cnt, 1'b0};
    w_a_sl       = r_a[w_bit_idx +: 2];
    w_nb_sl      = r_nb[w_bit_idx +: 2];
    w_g          = w_a_sl & w_nb_sl;
    w_p          = w_a_sl ^ w_nb_sl;
    w_c1         = w_g[0] | (w_p[0] & r_carry);
    w_cout       = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    w_s          = {w_p[1] ^ w_c1, w_p[0] ^ r_carry};
    // Result bits above the current slice are still 0, so OR-ing inserts the slice
    w_slice_diff = r_diff | (WIDTH'(w_s) << w_bit_idx);
    w_last       = (r_cnt == LastCnt);
  end

  // Next-state and datapath-update logic; clear overrides everything
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_nb_nxt     = r_nb;
    w_diff_nxt   = r_diff;
    w_cnt_nxt    = r_cnt;
    w_carry_nxt  = r_carry;
    w_borrow_nxt = r_borrow;
    w_zero_nxt   = r_zero;
`ifdef SUB_OVF_EN
    w_b_msb_nxt  = r_b_msb;
    w_ovf_nxt    = r_ovf;
`endif
    if (i_clear) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            w_state_nxt = StRun;
            w_a_nxt     = i_a;
            w_nb_nxt    = ~i_b;
            w_carry_nxt = 1'b1;  // +1 completes the two's complement of b
            w_cnt_nxt   = '0;
            w_diff_nxt  = '0;
`ifdef SUB_OVF_EN
            w_b_msb_nxt = i_b[WIDTH-1];
`endif
          end
        end
        StRun: begin
          w_diff_nxt  = w_slice_diff;
          w_carry_nxt = w_cout;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (w_last) begin
            w_state_nxt  = StDone;
            w_cnt_nxt    = '0;
            w_borrow_nxt = ~w_cout;
            w_zero_nxt   = (w_slice_diff == '0);
`ifdef SUB_OVF_EN
            w_ovf_nxt    = (r_a[WIDTH-1] != r_b_msb) &
                           (w_slice_diff[WIDTH-1] != r_a[WIDTH-1]);
`endif
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand, carry, counter and result registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a      <= '0;
      r_nb     <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_a      <= w_a_nxt;
      r_nb     <= w_nb_nxt;
      r_diff   <= w_diff_nxt;
      r_cnt    <= w_cnt_nxt;
      r_carry  <= w_carry_nxt;
      r_borrow <= w_borrow_nxt;
      r_zero   <= w_zero_nxt;
    end
  end

`ifdef SUB_OVF_EN
  // Subtrahend sign bit and overflow flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_b_msb <= w_b_msb_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign o_ovf = r_ovf;
`endif

  assign o_busy   = (r_state == StRun);
  assign o_done   = (r_state == StDone);
  assign o_diff   = r_diff;
  assign o_borrow = r_borrow;
  assign o_zero   = r_zero;

endmodule

// File: doc/cla_sub_serial.md
Name: cla_sub_serial

Overview:
- Multi-cycle unsigned/two's-complement subtractor: computes diff = a - b (mod 2^WIDTH).
- Processes 2 bits per clock using a 2-bit carry-lookahead slice (a + ~b + carry).
- The carry is registered between slices.
- Inverse-operation companion to the CLA adder tree; used where area matters more than latency (ALU compare/subtract path).

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.
- CNT_W, 5, width of slice counter; must satisfy 2^CNT_W >= WIDTH/2.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend, latched on accepted start
- b  input  WIDTH  subtrahend, latched on accepted start
- clear  input  1  synchronous abort, returns to IDLE
- busy  output  1  high while in RUN
- done  output  1  high in DONE; result valid
- diff  output  WIDTH  a - b mod 2^WIDTH
- borrow  output  1  1 iff a < b (unsigned)
- zero  output  1  1 iff diff == 0
- ovf  output  1  signed overflow (only with SUB_OVF_EN)

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, diff=0, borrow=0, zero=0, ovf=0, counter=0, carry reg=0.
- Reset asserted mid-RUN aborts immediately; no partial result is retained.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1:
  - latch a into A_r and ~b into NB_r;
  - carry reg=1 (two's-complement +1);
  - counter=0; diff cleared to 0; done=0; busy=1.
- RUN, each edge:
  - slice k=counter takes A_r[2k+1:2k], NB_r[2k+1:2k] and carry reg;
  - computes s[1:0] via generate/propagate lookahead: c1=g0|p0&cin, cout=g1|p1&g0|p1&p0&cin;
  - writes diff[2k+1:2k]=s; carry reg=cout; counter++.
- RUN -> DONE on the edge where counter==WIDTH/2-1 (its slice is also written):
  - borrow=~cout;
  - zero=(final diff==0);
  - ovf=(A_r[W-1]!=b_r[W-1]) & (diff[W-1]!=A_r[W-1]);
  - busy=0; done=1.
- Latency: start accepted at edge E0 -> done=1 after edge E0+WIDTH/2 (16 cycles for WIDTH=32).
- DONE:
  - outputs held stable;
  - start=1 accepts new operands exactly as in IDLE (back-to-back): done drops, busy rises on the same edge;
  - otherwise stays in DONE.
- start while busy=1 is ignored; operands are not re-latched.
- clear=1 (any state) -> IDLE next edge, busy=0, done=0; diff/borrow/zero/ovf retain their values but are not valid.
- clear has priority over start on the same edge.
- diff bits not yet computed read 0 during RUN; consumers must qualify with done.
- Wrap-around: result is modulo 2^WIDTH; borrow reports underflow; no saturation.

Optional Feature:
- Macro SUB_OVF_EN.
- Defined:
  - ovf port and signed-overflow logic present;
  - b MSB kept in a 1-bit register b_r for the ovf equation.
- Undefined:
  - ovf port absent;
  - no b_r register;
  - all other behaviour and latency identical.

Test Plan:
- WIDTH=32, a=100, b=58, start pulse -> after 16 cycles done=1, diff=42, borrow=0, zero=0, ovf=0; busy high for exactly 16 cycles.
- a=0, b=1 -> diff=0xFFFFFFFF, borrow=1, zero=0, ovf=0.
- a=b=0x12345678 -> diff=0, zero=1, borrow=0.
- a=0x80000000, b=1 (SUB_OVF_EN) -> diff=0x7FFFFFFF, ovf=1, borrow=0.
- start with a=5, b=3, then start with a=9, b=9 at cycle 4 of RUN -> second request ignored; done gives diff=2.
- Back-to-back via DONE: start a=7, b=2 on the done cycle -> next result diff=5 after 16 more cycles.
- Reset and clear: rst asserted at cycle 8 of RUN -> all outputs 0 asynchronously. clear at cycle 3 -> IDLE, done never asserted. New start afterwards computes correctly.
